// File: rtl/gf2m_operand_sequencer.sv
// Operand register and MSB-first digit streamer in front of the gf2m multiplier.
// Define GF2M_SEQ_CHECK_EN to build the sticky mul_done protocol checker on err.
module gf2m_operand_sequencer #(
    parameter int DIGITAL    = 4,
    parameter int DATA_WIDTH = 163,
    parameter int NUM_DIGITS = DATA_WIDTH / DIGITAL + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic [DATA_WIDTH-1:0] in_g,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_c,
    output logic                  mul_start,
    output logic [DATA_WIDTH-1:0] mul_a,
    output logic [DATA_WIDTH-1:0] mul_g,
    output logic [DIGITAL-1:0]    mul_b,
    input  logic [DATA_WIDTH-1:0] mul_t,
    input  logic                  mul_done,
    output logic                  err
);

    localparam int SR_W  = NUM_DIGITS * DIGITAL;
    localparam int CNT_W = $clog2(NUM_DIGITS + 1);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FEED,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                state_q;
    logic                  in_ready_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] g_q;
    logic [SR_W-1:0]       sr_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DIGITAL-1:0]    mul_b_q;
    logic                  mul_start_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_c_q;

    // b zero-extended on top so the pad digit(s) lead the Horner stream.
    logic [SR_W-1:0] b_ext;
    assign b_ext = {{(SR_W - DATA_WIDTH){1'b0}}, in_b};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b0;
            a_q         <= '0;
            g_q         <= '0;
            sr_q        <= '0;
            cnt_q       <= '0;
            mul_b_q     <= '0;
            mul_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_c_q     <= '0;
        end else begin
            mul_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_ready_q && in_valid) begin
                        a_q         <= in_a;
                        g_q         <= in_g;
                        // Digit 0 goes straight to mul_b; the register keeps digits 1..N-1.
                        mul_b_q     <= b_ext[SR_W-1 -: DIGITAL];
                        sr_q        <= b_ext << DIGITAL;
                        mul_start_q <= 1'b1;
                        in_ready_q  <= 1'b0;
                        state_q     <= S_START;
                    end
                end
                S_START: begin
                    cnt_q   <= '0;
                    state_q <= S_FEED;
                end
                S_FEED: begin
                    if (cnt_q == LAST_DIGIT) begin
                        mul_b_q <= '0;
                        state_q <= S_WAIT;
                    end else begin
                        mul_b_q <= sr_q[SR_W-1 -: DIGITAL];
                        sr_q    <= sr_q << DIGITAL;
                        cnt_q   <= cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    // gf2m clears t_i_j one cycle after done, so capture on the pulse itself.
                    if (mul_done) begin
                        out_c_q     <= mul_t;
                        out_valid_q <= 1'b1;
                        state_q     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_c     = out_c_q;
    assign mul_start = mul_start_q;
    assign mul_a     = a_q;
    assign mul_g     = g_q;
    assign mul_b     = mul_b_q;

`ifdef GF2M_SEQ_CHECK_EN
    logic first_wait_q;
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_wait_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            first_wait_q <= (state_q == S_FEED) && (cnt_q == LAST_DIGIT);
            if ((mul_done && (state_q != S_WAIT)) || (first_wait_q && !mul_done)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gf2m_operand_sequencer.sv
// Bench for gf2m_operand_sequencer: gf2m stand-in, field-arithmetic scoreboard and directed vectors.
module tb_gf2m_operand_sequencer;

    localparam int DIG = 4;
    localparam int DW  = 163;
    localparam int ND  = DW / DIG + 1;
    localparam int SRW = ND * DIG;
    localparam logic [DW-1:0] G = 163'hC9;
`ifdef GF2M_SEQ_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_a = '0, in_b = '0, in_g = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_c;
    logic          mul_start;
    logic [DW-1:0] mul_a, mul_g;
    logic [DIG-1:0] mul_b;
    logic [DW-1:0] emu_t = '0;
    logic          emu_done = 1'b0;
    logic          force_done = 1'b0;
    logic          mul_done;
    logic          err;

    assign mul_done = emu_done | force_done;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    gf2m_operand_sequencer #(.DIGITAL(DIG), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_g(in_g),
        .out_valid(out_valid), .out_ready(out_ready), .out_c(out_c),
        .mul_start(mul_start), .mul_a(mul_a), .mul_g(mul_g), .mul_b(mul_b),
        .mul_t(emu_t), .mul_done(mul_done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] xtime(input logic [DW-1:0] x, input logic [DW-1:0] g);
        return {x[DW-2:0], 1'b0} ^ (x[DW-1] ? g : '0);
    endfunction

    function automatic logic [DW-1:0] gf_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] g);
        logic [DW-1:0] r;
        r = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            r = xtime(r, g);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    // Digit k of b, counted from the top of the zero-padded word.
    function automatic logic [DIG-1:0] digit(input logic [DW-1:0] b, input int k);
        logic [SRW-1:0] e;
        e = '0;
        e[DW-1:0] = b;
        e = e >> (DIG * (ND - 1 - k));
        return e[DIG-1:0];
    endfunction

    task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // gf2m stand-in: Horner-evaluates the streamed digits and pulses done one cycle after the last.
    initial begin
        logic          coll;
        int            n;
        logic [DW-1:0] r, ea, eg;
        coll = 1'b0;
        n = 0;
        r = '0; ea = '0; eg = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                coll = 1'b0;
            end else if (mul_start) begin
                coll = 1'b1;
                n = 0;
                r = '0;
                ea = mul_a;
                eg = mul_g;
            end else if (coll) begin
                for (int i = DIG - 1; i >= 0; i--) begin
                    r = xtime(r, eg);
                    if (mul_b[i]) r = r ^ ea;
                end
                n++;
                if (n == ND) begin
                    coll = 1'b0;
                    @(posedge clk); #1;
                    emu_done = 1'b1;
                    emu_t = r;
                    @(posedge clk); #1;
                    emu_done = 1'b0;
                    emu_t = '0;
                end
            end
        end
    end

    // Transaction-level model: m_off is the cycle index since the accept edge (START = 1).
    logic          m_ready = 1'b0, m_busy = 1'b0, m_hold = 1'b0, m_err = 1'b0;
    int            m_off = 0;
    logic [DW-1:0] m_a = '0, m_g = '0, m_b = '0, m_c = '0, m_exp = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ready = 1'b0; m_busy = 1'b0; m_hold = 1'b0; m_err = 1'b0; m_off = 0;
            m_a = '0; m_g = '0; m_b = '0; m_c = '0;
        end else begin
`ifdef GF2M_SEQ_CHECK_EN
            if (mul_done && !(m_busy && m_off >= ND + 2)) m_err = 1'b1;
            if (m_busy && m_off == ND + 2 && !mul_done) m_err = 1'b1;
`endif
            if (m_hold) begin
                if (out_ready) begin
                    m_hold = 1'b0;
                    m_ready = 1'b1;
                end
            end else if (m_busy) begin
                if (m_off >= ND + 2 && mul_done) begin
                    m_c = m_exp;
                    m_hold = 1'b1;
                    m_busy = 1'b0;
                end else begin
                    m_off++;
                end
            end else if (m_ready && in_valid) begin
                m_busy = 1'b1;
                m_off = 1;
                m_ready = 1'b0;
                m_a = in_a; m_g = in_g; m_b = in_b;
                m_exp = gf_mul(in_a, in_b, in_g);
            end else begin
                m_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic [DIG-1:0] eb;
        eb = '0;
        if (m_busy && m_off >= 1 && m_off <= ND + 1) eb = digit(m_b, (m_off <= 2) ? 0 : m_off - 2);
        chk1("in_ready", in_ready, m_ready);
        chk1("mul_start", mul_start, m_busy && m_off == 1);
        chkw("mul_b", DW'(mul_b), DW'(eb));
        chkw("mul_a", mul_a, m_a);
        chkw("mul_g", mul_g, m_g);
        chk1("out_valid", out_valid, m_hold);
        chkw("out_c", out_c, m_c);
        chk1("err", err, m_err);
    end

    logic [DIG-1:0] bseq [0:127];

    // Offers an operand set and returns at the negedge of cycle 1 (START).
    task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] g);
        int guard;
        @(negedge clk);
        in_a = a; in_b = b; in_g = g; in_valid = 1'b1;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (in_ready !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: in_ready got %b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // From cycle 1, waits for out_valid; k ends as the cycle index where it rose.
    task automatic wait_result(input int force_at, output int k);
        k = 1;
        bseq[1] = mul_b;
        chk1("start_cycle1", mul_start, 1'b1);
        while (out_valid !== 1'b1 && k < 120) begin
            @(negedge clk);
            k++;
            bseq[k] = mul_b;
            force_done = (force_at != 0 && k == force_at);
            chk1("start_only_cycle1", mul_start, 1'b0);
        end
        force_done = 1'b0;
        if (out_valid !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL result_timeout: out_valid got %b required 1", out_valid);
        end
    endtask

    initial begin
        int            k;
        logic [DW-1:0] top, lit;
        top = '0;
        top[DW-1] = 1'b1;
        lit = 163'h8;
        chkw("model_pin_mul", gf_mul(163'h2, 163'h4, G), lit);
        chkw("model_pin_reduce", gf_mul(top, 163'h2, G), G);

        repeat (3) @(negedge clk);
        chk1("in_ready_in_reset", in_ready, 1'b0);
        #2 rst = 1'b1;
        @(negedge clk);
        chk1("in_ready_after_reset", in_ready, 1'b1);

        issue(163'h2, 163'h4, G);
        wait_result(0, k);
        chkw("c_2x4", out_c, 163'h8);
        chki("out_valid_cycle", k, ND + 3);
        $display("op a=2 b=4 -> c=%h valid_cycle=%0d", out_c, k);

        issue(top, 163'h2, G);
        wait_result(0, k);
        chkw("c_reduce", out_c, G);
        $display("op a=x^162 b=2 -> c=%h valid_cycle=%0d", out_c, k);

        issue(163'h1, 163'h5A, G);
        wait_result(0, k);
        chkw("digit_c40", DW'(bseq[40]), DW'(4'h0));
        chkw("digit_c41", DW'(bseq[41]), DW'(4'h5));
        chkw("digit_c42", DW'(bseq[42]), DW'(4'hA));
        chkw("digit_c43", DW'(bseq[43]), DW'(4'h0));
        chkw("c_5a", out_c, 163'h5A);
        $display("op a=1 b=5a -> c=%h digits c41=%h c42=%h", out_c, bseq[41], bseq[42]);

        issue(163'h3, 163'h5, G);
        out_ready = 1'b0;
        wait_result(0, k);
        chkw("c_bp_first", out_c, 163'hF);
        $display("op a=3 b=5 -> c=%h held under back-pressure", out_c);
        in_a = 163'h10; in_b = 163'h10; in_g = G; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk1("bp_in_ready", in_ready, 1'b0);
            chk1("bp_out_valid", out_valid, 1'b1);
            chkw("bp_out_c", out_c, 163'hF);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk1("bp_release_valid", out_valid, 1'b0);
        chk1("bp_release_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result(0, k);
        chkw("c_bp_second", out_c, 163'h100);
        $display("op a=10 b=10 -> c=%h after handshake", out_c);

        issue(163'h6, 163'h3, G);
        wait_result(10, k);
        chkw("c_forced", out_c, 163'hA);
        chk1("err_after_force", err, EXP_ERR);
        @(negedge clk);
        chk1("err_sticky", err, EXP_ERR);
        $display("op a=6 b=3 -> c=%h err=%b", out_c, err);
        #2 rst = 1'b0;
        @(negedge clk);
        chk1("err_cleared", err, 1'b0);
        #2 rst = 1'b1;
        @(negedge clk);

        issue(163'h7, 163'h9, G);
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk1("rst_mul_start", mul_start, 1'b0);
        chkw("rst_mul_b", DW'(mul_b), '0);
        chkw("rst_mul_a", mul_a, '0);
        chkw("rst_out_c", out_c, '0);
        chk1("rst_out_valid", out_valid, 1'b0);
        #2 rst = 1'b1;
        @(negedge clk);
        chk1("rst_release_ready", in_ready, 1'b1);
        issue(163'h1, 163'h1, G);
        wait_result(0, k);
        chkw("c_after_reset", out_c, 163'h1);
        $display("op a=1 b=1 -> c=%h after mid-feed reset", out_c);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
